// File: rtl/rv32_pc_redirect_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg : shared types for the PC redirect controller               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32_pkg;

  // Encoding order doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } redirect_src_e;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } pc_ctrl_state_e;

  typedef struct packed {
    redirect_src_e src;
    logic [31:0]   target;
  } redirect_t;

endpackage
`default_nettype wire

// File: rtl/rv32_pc_redirect_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pc_redirect_ctrl_if : fetch handshake, redirect and PC controls |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rv32_pc_redirect_ctrl_if;

  logic        pipe_stall;
  logic        fetch_req;
  logic        fetch_ack;
  logic        trap_req;
  logic [31:0] trap_target;
  logic        br_req;
  logic [31:0] br_target;
  logic        jmp_req;
  logic [31:0] jmp_target;
  logic        pc_stall;
  logic        pc_overwrite_enable;
  logic [31:0] pc_overwrite_data;
  logic        flush;
  logic        redirect_misaligned;

  modport master (
    input  pipe_stall, fetch_ack,
    input  trap_req, trap_target, br_req, br_target, jmp_req, jmp_target,
    output fetch_req, pc_stall, pc_overwrite_enable, pc_overwrite_data,
    output flush, redirect_misaligned
  );

  modport slave (
    output pipe_stall, fetch_ack,
    output trap_req, trap_target, br_req, br_target, jmp_req, jmp_target,
    input  fetch_req, pc_stall, pc_overwrite_enable, pc_overwrite_data,
    input  flush, redirect_misaligned
  );

endinterface
`default_nettype wire

// File: rtl/rv32_pc_redirect_ctrl_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_redirect_arb : picks the winning redirect among pending + new   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rv32_redirect_arb
  import rv32_pkg::*;
(
  input  redirect_t   pend,
  input  logic        trap_req,
  input  logic [31:0] trap_target,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  output redirect_t   winner,
  output logic        active
);

  redirect_t incoming;

  always_comb begin
    incoming = '0;
    if (trap_req) begin
      incoming.src    = SRC_TRAP;
      incoming.target = trap_target;
    end else if (br_req) begin
      incoming.src    = SRC_BR;
      incoming.target = br_target;
    end else if (jmp_req) begin
      incoming.src    = SRC_JMP;
      incoming.target = jmp_target;
    end

    // Ties go to the incoming request: it carries the newer target.
    if (incoming.src >= pend.src) begin
      winner = incoming;
    end else begin
      winner = pend;
    end
    active = (winner.src != SRC_NONE);
  end

endmodule
`default_nettype wire

// File: rtl/rv32_pc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pc_redirect_ctrl : PC sequencing, redirect hold and flush FSM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rv32_pc_redirect_ctrl
  import rv32_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  rv32_pc_redirect_ctrl_if.master   bus
);

  localparam logic [2:0] C_FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  pc_ctrl_state_e state_q, state_d;
  redirect_t      pend_q, pend_d;
  logic [2:0]     cnt_q, cnt_d;

  redirect_t      winner;
  logic           active;

  logic           fetch_req;
  logic           pc_stall;
  logic           ow_en;
  logic [31:0]    ow_data;
  logic           flush;
  logic           misaligned;

  rv32_redirect_arb u_arb (
    .pend        (pend_q),
    .trap_req    (bus.trap_req),
    .trap_target (bus.trap_target),
    .br_req      (bus.br_req),
    .br_target   (bus.br_target),
    .jmp_req     (bus.jmp_req),
    .jmp_target  (bus.jmp_target),
    .winner      (winner),
    .active      (active)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET;
      pend_q  <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    fetch_req  = 1'b0;
    pc_stall   = 1'b1;
    ow_en      = 1'b0;
    ow_data    = 32'd0;
    flush      = 1'b0;
    misaligned = 1'b0;

    case (state_q)
      RESET: begin
        flush   = 1'b1;
        state_d = FETCH;
        if (active) pend_d = winner;
      end

      FETCH: begin
        // A redirect overrides a hazard stall so the target gets fetched.
        fetch_req = !bus.pipe_stall || active;
        if (fetch_req && bus.fetch_ack) begin
          pc_stall = 1'b0;
          if (active) begin
            ow_en      = 1'b1;
            ow_data    = {winner.target[31:1], 1'b0};
            misaligned = winner.target[0];
            flush      = 1'b1;
            pend_d     = '0;
            cnt_d      = 3'd0;
            state_d    = FLUSH;
          end
        end else if (active) begin
          pend_d = winner;
        end
      end

      FLUSH: begin
        flush = 1'b1;
        if (active) pend_d = winner;
        if (cnt_q == C_FLUSH_LAST) begin
          cnt_d   = 3'd0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = RESET;
      end
    endcase
  end

  assign bus.fetch_req           = fetch_req;
  assign bus.pc_stall            = pc_stall;
  assign bus.pc_overwrite_enable = ow_en;
  assign bus.pc_overwrite_data   = ow_data;
  assign bus.flush               = flush;
  assign bus.redirect_misaligned = misaligned;

endmodule
`default_nettype wire

// File: tb/tb_rv32_pc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv32_pc_redirect_ctrl : directed checks of the redirect controller|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rv32_pc_redirect_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  rv32_pc_redirect_ctrl_if bus ();

  rv32_pc_redirect_ctrl #(.FLUSH_CYCLES(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.trap_req = 1'b0;
    bus.br_req   = 1'b0;
    bus.jmp_req  = 1'b0;
  endtask

  // Compares the full output set against one expected vector.
  task automatic check_outs(input string tag, input logic fr, input logic ps, input logic ow,
                            input logic [31:0] od, input logic fl, input logic mis);
    check_eq({tag, ".fetch_req"}, 32'(bus.fetch_req), 32'(fr));
    check_eq({tag, ".pc_stall"},  32'(bus.pc_stall),  32'(ps));
    check_eq({tag, ".ow_en"},     32'(bus.pc_overwrite_enable), 32'(ow));
    check_eq({tag, ".ow_data"},   bus.pc_overwrite_data, od);
    check_eq({tag, ".flush"},     32'(bus.flush), 32'(fl));
    check_eq({tag, ".misalign"},  32'(bus.redirect_misaligned), 32'(mis));
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.pipe_stall  = 1'b0;
    bus.fetch_ack   = 1'b0;
    bus.trap_target = 32'd0;
    bus.br_target   = 32'd0;
    bus.jmp_target  = 32'd0;
    clear_reqs();

    // 1: reset, one RESET cycle, then ack every cycle
    repeat (3) next_cycle();
    sample();
    check_outs("rst", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    reset_n = 1'b1;
    sample();
    check_outs("rst_state", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    bus.fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_outs("seq", 1, 0, 0, 32'd0, 0, 0);
      next_cycle();
    end

    // 2: branch with ack in the same cycle
    bus.br_req    = 1'b1;
    bus.br_target = 32'h1000_0100;
    sample();
    check_outs("br_apply", 1, 0, 1, 32'h1000_0100, 1, 0);
    next_cycle();
    clear_reqs();
    bus.fetch_ack = 1'b0;
    sample();
    check_outs("br_flush", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();

    // 3: jump pending, trap arrives and replaces it, ack two cycles later
    bus.jmp_req    = 1'b1;
    bus.jmp_target = 32'h1000_0200;
    sample();
    check_outs("jmp_wait", 1, 1, 0, 32'd0, 0, 0);
    next_cycle();
    bus.jmp_req     = 1'b0;
    bus.trap_req    = 1'b1;
    bus.trap_target = 32'h1000_0004;
    sample();
    check_outs("trap_wait", 1, 1, 0, 32'd0, 0, 0);
    next_cycle();
    bus.trap_req = 1'b0;
    sample();
    check_outs("pend_wait", 1, 1, 0, 32'd0, 0, 0);
    next_cycle();
    bus.fetch_ack = 1'b1;
    sample();
    check_outs("trap_apply", 1, 0, 1, 32'h1000_0004, 1, 0);
    next_cycle();
    bus.fetch_ack = 1'b0;
    sample();
    check_outs("trap_flush", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    bus.fetch_ack = 1'b1;
    sample();
    check_outs("jmp_dropped", 1, 0, 0, 32'd0, 0, 0);
    next_cycle();

    // 4: trap and branch together
    bus.trap_req    = 1'b1;
    bus.trap_target = 32'h1000_0080;
    bus.br_req      = 1'b1;
    bus.br_target   = 32'h1000_0300;
    sample();
    check_outs("trap_over_br", 1, 0, 1, 32'h1000_0080, 1, 0);
    next_cycle();
    clear_reqs();
    sample();
    check_outs("t4_flush", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    sample();
    check_outs("br_dropped", 1, 0, 0, 32'd0, 0, 0);
    next_cycle();

    // 5: misaligned jump target
    bus.jmp_req    = 1'b1;
    bus.jmp_target = 32'h1000_0011;
    sample();
    check_outs("mis_apply", 1, 0, 1, 32'h1000_0010, 1, 1);
    next_cycle();
    clear_reqs();
    sample();
    check_outs("mis_gone", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();

    // 6a: pending branch mid-FLUSH, then reset discards it
    bus.jmp_req    = 1'b1;
    bus.jmp_target = 32'h1000_0500;
    sample();
    check_outs("t6_apply", 1, 0, 1, 32'h1000_0500, 1, 0);
    next_cycle();
    clear_reqs();
    bus.fetch_ack = 1'b0;
    bus.br_req    = 1'b1;
    bus.br_target = 32'h1000_0600;
    sample();
    check_outs("t6_flush", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    clear_reqs();
    sample();
    check_outs("t6_pend", 1, 1, 0, 32'd0, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check_outs("t6_in_rst", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    reset_n = 1'b1;
    sample();
    check_outs("t6_rst_state", 0, 1, 0, 32'd0, 1, 0);
    next_cycle();
    bus.fetch_ack = 1'b1;
    sample();
    check_outs("t6_no_ow", 1, 0, 0, 32'd0, 0, 0);
    next_cycle();

    // 6b: hazard stall without redirect; ack is ignored while fetch_req=0
    bus.pipe_stall = 1'b1;
    sample();
    check_outs("hazard", 0, 1, 0, 32'd0, 0, 0);
    next_cycle();
    bus.fetch_ack = 1'b0;
    bus.br_req    = 1'b1;
    bus.br_target = 32'h1000_0700;
    sample();
    check_outs("hazard_br", 1, 1, 0, 32'd0, 0, 0);
    next_cycle();
    clear_reqs();
    bus.fetch_ack = 1'b1;
    sample();
    check_outs("hazard_pend", 1, 0, 1, 32'h1000_0700, 1, 0);
    next_cycle();
    bus.pipe_stall = 1'b0;
    bus.fetch_ack  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
